// File: rtl/mux_demux_router.sv
// Routes one of CH input lanes to one of CH output lanes through registered
// route selects, either loaded on command (manual) or walked by a dwell counter (scan).
module mux_demux_router #(
  parameter int WIDTH = 1,
  parameter int CH    = 4,
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      mux_sel,
  input  logic [SEL_W-1:0]      demux_sel,
  input  logic [CH*WIDTH-1:0]   in_data,
  output logic [CH*WIDTH-1:0]   out_data,
  output logic [CH-1:0]         out_valid,
  output logic [SEL_W-1:0]      cur_mux,
  output logic [SEL_W-1:0]      cur_demux
);

  localparam int DW_W = $clog2(DWELL) + 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(CH - 1);

  logic [SEL_W-1:0]    r_mux;
  logic [SEL_W-1:0]    r_demux;
  logic [DW_W-1:0]     r_dwell;
  logic                r_prevScan;
  logic [CH*WIDTH-1:0] r_outData;
  logic [CH-1:0]       r_outValid;

  logic [SEL_W-1:0]    w_muxNext;
  logic [SEL_W-1:0]    w_demuxNext;
  logic [DW_W-1:0]     w_dwellNext;
  logic [WIDTH-1:0]    w_lane;
  logic [CH*WIDTH-1:0] w_outData;
  logic [CH-1:0]       w_outValid;

  // The first manual edge after scanning keeps the scanned route, so a load
  // held across the switch does not overwrite it.
  always_comb begin
    w_muxNext   = r_mux;
    w_demuxNext = r_demux;
    w_dwellNext = r_dwell;
    if (mode) begin
      if (r_dwell == DWELL_LAST) begin
        w_dwellNext = '0;
        w_muxNext   = r_mux + SEL_W'(1);
        if (r_mux == SEL_LAST) begin
          w_demuxNext = r_demux + SEL_W'(1);
        end
      end else begin
        w_dwellNext = r_dwell + DW_W'(1);
      end
    end else begin
      w_dwellNext = '0;
      if (load && !r_prevScan) begin
        w_muxNext   = mux_sel;
        w_demuxNext = demux_sel;
      end
    end
  end

  always_comb begin
    w_lane     = '0;
    w_outData  = '0;
    w_outValid = '0;
    for (int i = 0; i < CH; i++) begin
      if (r_mux == SEL_W'(i)) begin
        w_lane = in_data[i*WIDTH +: WIDTH];
      end
    end
    for (int j = 0; j < CH; j++) begin
      if (r_demux == SEL_W'(j)) begin
        w_outData[j*WIDTH +: WIDTH] = w_lane;
        w_outValid[j]               = 1'b1;
      end
    end
  end

  // Disabled edges blank the outputs but leave route and dwell state untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mux      <= '0;
      r_demux    <= '0;
      r_dwell    <= '0;
      r_prevScan <= 1'b0;
      r_outData  <= '0;
      r_outValid <= '0;
    end else if (en) begin
      r_mux      <= w_muxNext;
      r_demux    <= w_demuxNext;
      r_dwell    <= w_dwellNext;
      r_prevScan <= mode;
      r_outData  <= w_outData;
      r_outValid <= w_outValid;
    end else begin
      r_outData  <= '0;
      r_outValid <= '0;
    end
  end

  assign out_data  = r_outData;
  assign out_valid = r_outValid;
  assign cur_mux   = r_mux;
  assign cur_demux = r_demux;

endmodule
